call_ret_ctrl: RTL and testbench
================================

Name: call_ret_ctrl

Overview:
Sequencer directly upstream of the 16-bit return-address stack. It turns decoded CALL/RET commands into phase-aligned push/pop strobes: push only in phase 1, pop only in phase 0. On RET it captures the popped word from the stack and loads it into the PC. It tracks stack depth and flags overflow and underflow so that no push or pop reaches the stack when it would corrupt it.

Parameters:
DW, 16, data and address width
DEPTH, 11, usable stack entries (stack base index 1, 12 locations)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
count  in  2  core phase counter; advances 0,1,2,3,0 once per clk
cmd_op  in  2  00 NOP, 01 CALL, 10 RET, 11 reserved
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
target_addr  in  DW  CALL destination
ret_addr  in  DW  return address (PC+1), pushed on CALL
stk_push  out  1  to stack push
stk_pop  out  1  to stack pop
stk_din  out  DW  to stack data_in
stk_dout  in  DW  from stack data_out
pc_load  out  1  one-cycle pulse: PC <= pc_next
pc_next  out  DW  new PC value
depth  out  4  current entry count, 0..DEPTH
overflow  out  1  sticky; set by CALL at depth==DEPTH
underflow  out  1  sticky; set by RET at depth==0
illegal  out  1  one-cycle pulse on accepted cmd_op==11

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE.
  - Outputs: stk_push=0, stk_pop=0, stk_din=0, pc_load=0, pc_next=0, depth=0, overflow=0, underflow=0, illegal=0.
  - rst dominates every state, including mid-push and mid-pop; no strobe may be asserted in the cycle after a reset edge.
  - System requirement: the stack pointer returns to base on the same rst.
- Command accept: at an edge with cmd_valid=1 and state IDLE.
  - NOP: ignored.
  - 11: pulse illegal next cycle, stay IDLE.
- State IDLE:
  - CALL with depth<DEPTH: latch ret_addr into stk_din and target_addr internally -> WAIT_PUSH.
  - CALL with depth==DEPTH: set overflow, no push, no pc_load, stay IDLE.
  - RET with depth>0 -> WAIT_POP.
  - RET with depth==0: set underflow, no pop, no pc_load, stay IDLE.
- State WAIT_PUSH:
  - stk_push is combinationally (count==1); stk_din stays stable for the whole state.
  - At the edge where count==1: depth+1, pc_next<=target, pc_load<=1 -> IDLE.
  - pc_load is visible the cycle after the push edge.
  - Exactly one push per CALL.
- State WAIT_POP:
  - stk_pop is combinationally (count==0).
  - At the edge where count==0: depth-1 -> CAPTURE.
- State CAPTURE (one cycle; stk_dout is now valid):
  - At the edge: pc_next<=stk_dout, pc_load<=1 -> IDLE.
  - Exactly one pop per RET.
- Latency: 1-4 cycles from accept to the stack edge, depending on count.
  - CALL: pc_load 1 cycle after the push edge.
  - RET: pc_load 2 cycles after the pop edge.
- pc_load: high exactly one cycle per successful CALL/RET; pc_next holds its value until the next load.
- cmd_valid while busy: not accepted; the issuer holds it until cmd_ready.
- Flags: overflow and underflow clear only on rst.
- Depth is computed in 4 bits and never wraps: the boundary checks prevent 0-1 and DEPTH+1.
- stk_push and stk_pop are never high in the same cycle.

Decomposition:
- Shared package (cpu_pkg):
  - DW
  - STACK_DEPTH
  - cmd_op encodings OP_NOP, OP_CALL, OP_RET
  - phase constants PH_PUSH=1, PH_POP=0
  - FSM state encoding IDLE, WAIT_PUSH, WAIT_POP, CAPTURE
- No sub-module. The depth counter and FSM are small enough to stay in one module. The bench instantiates call_ret_ctrl together with the stack.

Test Plan:
1. Reset, then CALL at count==2 with ret_addr=0x0011, target=0x0200 -> stk_push high only in the count==1 cycle; pc_load next cycle with pc_next=0x0200; depth=1.
2. Then RET at count==3 -> stk_pop high only at count==0; pc_load 2 cycles later with pc_next=0x0011; depth=0.
3. Three nested CALLs with ret 0x0A, 0x0B, 0x0C, then three RETs -> pc_next sequence 0x0C, 0x0B, 0x0A; depth returns to 0.
4. Eleven CALLs, then a twelfth -> depth=11; overflow=1; no twelfth push; no pc_load; stack contents intact.
5. RET at depth 0 -> underflow=1; no stk_pop; no pc_load. Then cmd_op=11 -> illegal pulses for one cycle, state stays IDLE.
6. rst asserted in WAIT_PUSH, before count reaches 1 -> no push observed; depth=0; flags 0; cmd_ready=1 next cycle. A following CALL behaves as in scenario 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CALL/RET sequencer: widths, command and phase
// encodings, and the sequencer FSM state type.
package cpu_pkg;

    localparam int DW          = 16;
    localparam int STACK_DEPTH = 11;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;

    // Phase in which the stack accepts each kind of strobe
    localparam logic [1:0] PH_PUSH = 2'd1;
    localparam logic [1:0] PH_POP  = 2'd0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PUSH = 2'd1,
        WAIT_POP  = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

endpackage

// File: rtl/call_ret_ctrl.sv
// CALL/RET sequencer in front of the return-address stack. Converts accepted
// commands into phase-aligned push/pop strobes, tracks stack depth, refuses
// pushes/pops that would overflow/underflow the stack, and loads the PC.
module call_ret_ctrl
    import cpu_pkg::*;
#(
    parameter int DW    = cpu_pkg::DW,
    parameter int DEPTH = cpu_pkg::STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    count,
    input  logic [1:0]    cmd_op,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] target_addr,
    input  logic [DW-1:0] ret_addr,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    output logic          pc_load,
    output logic [DW-1:0] pc_next,
    output logic [3:0]    depth,
    output logic          overflow,
    output logic          underflow,
    output logic          illegal
);

    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    state_t        state_reg, state_next;
    logic [DW-1:0] stk_din_reg, stk_din_next;
    logic [DW-1:0] target_reg, target_next;
    logic [DW-1:0] pc_next_reg, pc_next_next;
    logic          pc_load_reg, pc_load_next;
    logic [3:0]    depth_reg, depth_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          illegal_reg, illegal_next;

    // Register all sequencer state; reset returns everything to an empty stack
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            stk_din_reg   <= '0;
            target_reg    <= '0;
            pc_next_reg   <= '0;
            pc_load_reg   <= 1'b0;
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stk_din_reg   <= stk_din_next;
            target_reg    <= target_next;
            pc_next_reg   <= pc_next_next;
            pc_load_reg   <= pc_load_next;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            illegal_reg   <= illegal_next;
        end
    end

    // Next-state logic: command accept, depth bounds checks, phase waits
    always_comb begin
        state_next     = state_reg;
        stk_din_next   = stk_din_reg;
        target_next    = target_reg;
        pc_next_next   = pc_next_reg;
        pc_load_next   = 1'b0;
        depth_next     = depth_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        illegal_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_CALL: begin
                            if (depth_reg < DEPTH_MAX) begin
                                stk_din_next = ret_addr;
                                target_next  = target_addr;
                                state_next   = WAIT_PUSH;
                            end else begin
                                overflow_next = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (depth_reg != 4'd0) begin
                                state_next = WAIT_POP;
                            end else begin
                                underflow_next = 1'b1;
                            end
                        end
                        default: illegal_next = 1'b1;
                    endcase
                end
            end
            WAIT_PUSH: begin
                if (count == PH_PUSH) begin
                    depth_next   = depth_reg + 4'd1;
                    pc_next_next = target_reg;
                    pc_load_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            WAIT_POP: begin
                if (count == PH_POP) begin
                    depth_next = depth_reg - 4'd1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                // Stack data_out now holds the popped word
                pc_next_next = stk_dout;
                pc_load_next = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are gated by rst so a reset landing on the push/pop phase
    // never lets a strobe reach the stack.
    assign stk_push  = (state_reg == WAIT_PUSH) && (count == PH_PUSH) && !rst;
    assign stk_pop   = (state_reg == WAIT_POP)  && (count == PH_POP)  && !rst;
    assign cmd_ready = (state_reg == IDLE);
    assign stk_din   = stk_din_reg;
    assign pc_load   = pc_load_reg;
    assign pc_next   = pc_next_reg;
    assign depth     = depth_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: a behavioural return-address stack is attached to
// the strobes, and each command is compared against a queue-based model.
module tb_call_ret_ctrl;
    import cpu_pkg::*;

    localparam int W = cpu_pkg::DW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   count = 2'd0;
    logic [1:0]   cmd_op = 2'b00;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] target_addr = '0;
    logic [W-1:0] ret_addr = '0;
    logic         stk_push, stk_pop;
    logic [W-1:0] stk_din;
    logic [W-1:0] stk_dout = '0;
    logic         pc_load;
    logic [W-1:0] pc_next;
    logic [3:0]   depth;
    logic         overflow, underflow, illegal;

    call_ret_ctrl dut (
        .clk(clk), .rst(rst), .count(count), .cmd_op(cmd_op),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .target_addr(target_addr), .ret_addr(ret_addr),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .pc_load(pc_load), .pc_next(pc_next),
        .depth(depth), .overflow(overflow), .underflow(underflow),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Free-running core phase counter
    always @(posedge clk) count <= count + 2'd1;

    // Return-address stack: 12 locations, pointer resets to base 1
    logic [W-1:0] smem [0:11];
    logic [3:0]   sp;
    int           corrupt_n = 0;
    always @(posedge clk) begin
        if (rst) begin
            sp <= 4'd1;
        end else if (stk_push) begin
            if (sp > 4'd11) corrupt_n <= corrupt_n + 1;
            else begin
                smem[sp] <= stk_din;
                sp <= sp + 4'd1;
            end
        end else if (stk_pop) begin
            if (sp <= 4'd1) corrupt_n <= corrupt_n + 1;
            else begin
                stk_dout <= smem[sp - 4'd1];
                sp <= sp - 4'd1;
            end
        end
    end

    // Strobe monitor, sampled mid-cycle
    int cyc = 0, push_n = 0, pop_n = 0, load_n = 0, ill_n = 0, bad_n = 0;
    int push_cyc = 0, pop_cyc = 0, load_cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (stk_push) begin
                push_n = push_n + 1;
                push_cyc = cyc;
                if (count != PH_PUSH) bad_n = bad_n + 1;
            end
            if (stk_pop) begin
                pop_n = pop_n + 1;
                pop_cyc = cyc;
                if (count != PH_POP) bad_n = bad_n + 1;
            end
            if (stk_push && stk_pop) bad_n = bad_n + 1;
            if (pc_load) begin
                load_n = load_n + 1;
                load_cyc = cyc;
            end
            if (illegal) ill_n = ill_n + 1;
        end
    end

    // Reference model state
    logic [W-1:0] ref_q[$];
    logic [W-1:0] exp_pc = '0;
    logic         exp_ov = 1'b0, exp_un = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] tgt,
                           input logic [W-1:0] ra, input int ph);
        int p0, q0, l0, i0, e_push, e_pop, e_load, e_ill;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (cmd_ready && (ph < 0 || count == ph[1:0])) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("ready_wait", 32'(ok), 32'd1);
        p0 = push_n; q0 = pop_n; l0 = load_n; i0 = ill_n;
        cmd_valid = 1'b1; cmd_op = op; target_addr = tgt; ret_addr = ra;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'b00;
        target_addr = W'($urandom); ret_addr = W'($urandom);
        repeat (7) begin @(posedge clk); #1; end

        e_push = 0; e_pop = 0; e_load = 0; e_ill = 0;
        case (op)
            OP_CALL: if (ref_q.size() < STACK_DEPTH) begin
                ref_q.push_back(ra); exp_pc = tgt; e_push = 1; e_load = 1;
            end else exp_ov = 1'b1;
            OP_RET: if (ref_q.size() > 0) begin
                exp_pc = ref_q.pop_back(); e_pop = 1; e_load = 1;
            end else exp_un = 1'b1;
            2'b11: e_ill = 1;
            default: ;
        endcase

        chk("push_count", 32'(push_n - p0), 32'(e_push));
        chk("pop_count", 32'(pop_n - q0), 32'(e_pop));
        chk("pc_load_count", 32'(load_n - l0), 32'(e_load));
        chk("illegal_count", 32'(ill_n - i0), 32'(e_ill));
        chk("pc_next", 32'(pc_next), 32'(exp_pc));
        chk("depth", 32'(depth), 32'(ref_q.size()));
        chk("overflow", 32'(overflow), 32'(exp_ov));
        chk("underflow", 32'(underflow), 32'(exp_un));
        chk("strobe_phase", 32'(bad_n), 32'd0);
        chk("stack_corrupt", 32'(corrupt_n), 32'd0);
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        if (e_load == 1 && e_push == 1) chk("call_latency", 32'(load_cyc - push_cyc), 32'd1);
        if (e_load == 1 && e_pop == 1)  chk("ret_latency", 32'(load_cyc - pop_cyc), 32'd2);
        $display("txn op=%0d tgt=%04h ra=%04h pc_next=%04h depth=%0d ov=%0b un=%0b",
                 op, tgt, ra, pc_next, depth, overflow, underflow);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0, ph, r;
        logic [1:0] op;

        // Reset state
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk("rst_push", 32'(stk_push), 32'd0);
        chk("rst_pop", 32'(stk_pop), 32'd0);
        chk("rst_din", 32'(stk_din), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pc_next", 32'(pc_next), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_flags", {29'd0, overflow, underflow, illegal}, 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        $display("txn reset depth=%0d ready=%0b", depth, cmd_ready);

        // Basic CALL then RET at fixed phases
        run_cmd(OP_CALL, 16'h0200, 16'h0011, 2);
        run_cmd(OP_RET, 16'h0000, 16'h0000, 3);

        // Nested calls
        run_cmd(OP_CALL, 16'h1000, 16'h000A, -1);
        run_cmd(OP_CALL, 16'h2000, 16'h000B, 0);
        run_cmd(OP_CALL, 16'h3000, 16'h000C, 1);
        for (int i = 0; i < 3; i++) run_cmd(OP_RET, 16'h0, 16'h0, i);

        // Fill the stack, then overflow it, then drain to check contents
        for (int i = 0; i < STACK_DEPTH; i++)
            run_cmd(OP_CALL, W'($urandom), W'(16'h0100 + i), i % 4);
        run_cmd(OP_CALL, 16'hBEEF, 16'hDEAD, -1);
        for (int i = 0; i < STACK_DEPTH; i++)
            run_cmd(OP_RET, 16'h0, 16'h0, (i + 1) % 4);

        // Underflow and illegal opcode
        run_cmd(OP_RET, 16'h0, 16'h0, -1);
        run_cmd(2'b11, 16'h0, 16'h0, -1);
        run_cmd(OP_NOP, 16'h0, 16'h0, -1);

        // Reset while waiting to push, before the push phase
        for (int k = 0; k < 8 && !(cmd_ready && count == 2'd2); k++) begin
            @(posedge clk); #1;
        end
        p0 = push_n;
        cmd_valid = 1'b1; cmd_op = OP_CALL; target_addr = 16'h4444; ret_addr = 16'h5555;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midpush_ready", 32'(cmd_ready), 32'd1);
        chk("midpush_strobe", {30'd0, stk_push, stk_pop}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        chk("midpush_no_push", 32'(push_n - p0), 32'd0);
        chk("midpush_depth", 32'(depth), 32'd0);
        chk("midpush_flags", {30'd0, overflow, underflow}, 32'd0);
        $display("txn reset_mid_push depth=%0d ov=%0b un=%0b", depth, overflow, underflow);
        ref_q.delete();
        exp_ov = 1'b0; exp_un = 1'b0; exp_pc = 16'h0000;
        run_cmd(OP_CALL, 16'h0200, 16'h0011, 2);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      op = OP_CALL;
            else if (r < 9) op = OP_RET;
            else            op = (($urandom & 1) != 0) ? 2'b11 : OP_NOP;
            ph = int'($urandom_range(0, 4)) - 1;
            run_cmd(op, W'($urandom), W'($urandom), ph);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
